// File: rtl/kgp_prefix_adder_pipe.sv
// Pipelined WIDTH-bit adder/subtractor built on a Kogge-Stone KGP prefix tree,
// one register per prefix level, valid/ready flow control with a global stall.
module kgp_prefix_adder_pipe #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             op_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int L = $clog2(WIDTH);

  typedef enum logic [1:0] {
    KGP_K = 2'b00,
    KGP_P = 2'b01,
    KGP_G = 2'b11
  } kgp_t;

  // Node n carries the KGP symbol of bit position n-1; node 0 is the carry-in.
  typedef logic [WIDTH:0][1:0] kgp_vec_t;

  function automatic logic [1:0] kgp_combine(input logic [1:0] hi, input logic [1:0] lo);
    return (hi != KGP_P) ? hi : lo;
  endfunction

  logic             advance;
  logic [WIDTH-1:0] b_eff;
  logic             c0;
  kgp_vec_t         kgp_in;

  logic [L:0]       vld;
  logic [WIDTH-1:0] a_q   [0:L];
  logic [WIDTH-1:0] b_q   [0:L];
  kgp_vec_t         kgp_q [0:L];

  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] sum_d;

  // The whole pipe moves as one; only out_ready reaches in_ready combinationally.
  assign advance  = ~out_valid | out_ready;
  assign in_ready = advance;

  assign b_eff     = op_sub ? ~b : b;
  assign c0        = op_sub | cin;
  assign kgp_in[0] = {c0, c0};

  // {a&b, a|b} yields K=00, P=01, G=11 and never 10.
  for (genvar i = 0; i < WIDTH; i++) begin : g_gen
    assign kgp_in[i+1] = {a[i] & b_eff[i], a[i] | b_eff[i]};
  end

  // NOTE: datapath registers carry no reset; the valid bits alone decide whether
  // their contents mean anything, so resetting them would only cost routing.
  always_ff @(posedge clk) begin
    if (advance && in_valid) begin
      a_q[0]   <= a;
      b_q[0]   <= b_eff;
      kgp_q[0] <= kgp_in;
    end
  end

  for (genvar j = 1; j <= L; j++) begin : g_level
    localparam int D = 1 << (j - 1);
    kgp_vec_t lvl;

    for (genvar n = 0; n <= WIDTH; n++) begin : g_node
      if (n >= D) begin : g_comb
        assign lvl[n] = kgp_combine(kgp_q[j-1][n], kgp_q[j-1][n-D]);
      end else begin : g_pass
        assign lvl[n] = kgp_q[j-1][n];
      end
    end

    always_ff @(posedge clk) begin
      if (advance) begin
        a_q[j]   <= a_q[j-1];
        b_q[j]   <= b_q[j-1];
        kgp_q[j] <= lvl;
      end
    end
  end

  // After L levels every node below WIDTH already reaches the carry-in. The top
  // node spans one bit further, so it takes one last combine with node 0.
  for (genvar i = 0; i < WIDTH; i++) begin : g_carry
    assign c[i] = (kgp_q[L][i] == KGP_G);
  end
  assign c[WIDTH] = (kgp_combine(kgp_q[L][WIDTH], kgp_q[L][0]) == KGP_G);

  assign sum_d = a_q[L] ^ b_q[L] ^ c[WIDTH-1:0];

  // NOTE: sequential state uses non-blocking assignments so every stage samples
  // the pre-edge value of the stage behind it.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld       <= '0;
      out_valid <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
      zero      <= 1'b0;
    end else if (advance) begin
      vld       <= {vld[L-1:0], in_valid};
      out_valid <= vld[L];
      if (vld[L]) begin
        sum  <= sum_d;
        cout <= c[WIDTH];
        ovf  <= c[WIDTH] ^ c[WIDTH-1];
        zero <= ~|sum_d;
      end
    end
  end

endmodule

// File: tb/tb_kgp_prefix_adder_pipe.sv
// Scoreboard bench: drivers push expected results, negedge monitors pop and compare.
// Main instance is WIDTH=16; two side lanes run random traffic at WIDTH=4 and 64.
module tb_kgp_prefix_adder_pipe;

  localparam int W   = 16;
  localparam int LAT = $clog2(W) + 2;

  typedef struct {
    logic [63:0] sum;
    bit          cout;
    bit          ovf;
    bit          zero;
    bit          chk_lat;
    int          due;
  } exp_t;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         op_sub = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] sum;
  logic         cout, ovf, zero;

  exp_t q[$];
  bit   rand16_done = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  kgp_prefix_adder_pipe #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .op_sub(op_sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf), .zero(zero)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: plain unsigned and signed integer arithmetic on wide values.
  function automatic exp_t model(input int w, input logic [63:0] ma, input logic [63:0] mb,
                                 input bit mcin, input bit msub);
    exp_t r;
    logic signed [66:0] pow, mask, ua, ub, sa, sb, ci, u, s, t;
    pow  = 67'sd1 <<< w;
    mask = pow - 67'sd1;
    ua   = {3'b000, ma} & mask;
    ub   = {3'b000, mb} & mask;
    sa   = ua[w-1] ? ua - pow : ua;
    sb   = ub[w-1] ? ub - pow : ub;
    ci   = mcin;
    u    = msub ? ua - ub : ua + ub + ci;
    s    = msub ? sa - sb : sa + sb + ci;
    t    = u & mask;
    r.sum     = t[63:0];
    r.cout    = msub ? (ua >= ub) : (u >= pow);
    r.ovf     = (s >= (pow >>> 1)) || (s < -(pow >>> 1));
    r.zero    = (r.sum == 64'd0);
    r.chk_lat = 1'b0;
    r.due     = 0;
    return r;
  endfunction

  function automatic exp_t mk(input logic [63:0] s, input bit c, input bit o, input bit z);
    exp_t r;
    r.sum = s; r.cout = c; r.ovf = o; r.zero = z; r.chk_lat = 1'b1; r.due = 0;
    return r;
  endfunction

  function automatic logic [63:0] pick();
    case ($urandom_range(0, 7))
      0:       return '0;
      1:       return '1;
      2:       return 64'd1;
      default: return {$urandom, $urandom};
    endcase
  endfunction

  // Called at posedge+1; presents a beat, waits for acceptance, returns at posedge+1.
  task automatic send_exp(input logic [W-1:0] ta, input logic [W-1:0] tb, input bit tcin,
                          input bit tsub, input bit lat, input exp_t e);
    int waited = 0;
    a = ta; b = tb; cin = tcin; op_sub = tsub; in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL send_timeout: in_ready stayed 0 for %0d cycles, required 1", waited);
    end else begin
      e.chk_lat = lat;
      e.due     = cyc + LAT;
      q.push_back(e);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb, input bit tcin,
                      input bit tsub, input bit lat);
    send_exp(ta, tb, tcin, tsub, lat, model(W, 64'(ta), 64'(tb), tcin, tsub));
  endtask

  task automatic drain();
    int t = 0;
    while (q.size() != 0 && t < 500) begin
      @(negedge clk);
      t++;
    end
    if (q.size() != 0) begin
      checks++; errors++;
      $display("FAIL drain_timeout: %0d beats outstanding, required 0", q.size());
    end
    @(posedge clk); #1;
  endtask

  // Monitor for the 16-bit instance.
  logic [W-1:0] p_sum;
  logic [2:0]   p_flags;
  bit           p_hold = 0;

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      p_hold = 0;
    end else begin
      check("in_ready", in_ready, !out_valid || out_ready);
      if (p_hold) begin
        check("hold_valid", out_valid, 1'b1);
        check("hold_sum", sum, p_sum);
        check("hold_flags", {cout, ovf, zero}, p_flags);
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_beat: got sum 0x%0h, expected no output", sum);
        end else begin
          e = q.pop_front();
          check("sum", 64'(sum), e.sum);
          check("cout", cout, e.cout);
          check("ovf", ovf, e.ovf);
          check("zero", zero, e.zero);
          if (e.chk_lat) check("latency_cycle", cyc, e.due);
        end
      end
      p_hold  = out_valid && !out_ready;
      p_sum   = sum;
      p_flags = {cout, ovf, zero};
    end
  end

  // Side lanes: random traffic at other widths with their own scoreboards.
  for (genvar g = 0; g < 2; g++) begin : g_lane
    localparam int LW = (g == 0) ? 4 : 64;

    logic          l_rst = 1'b1;
    logic          l_in_valid = 1'b0;
    logic          l_in_ready;
    logic [LW-1:0] l_a = '0;
    logic [LW-1:0] l_b = '0;
    logic          l_cin = 1'b0;
    logic          l_sub = 1'b0;
    logic          l_out_valid;
    logic          l_out_ready = 1'b0;
    logic [LW-1:0] l_sum;
    logic          l_cout, l_ovf, l_zero;
    exp_t          lq[$];
    bit            l_done = 0;

    kgp_prefix_adder_pipe #(.WIDTH(LW)) u_dut (
      .clk(clk), .rst(l_rst), .in_valid(l_in_valid), .in_ready(l_in_ready),
      .a(l_a), .b(l_b), .cin(l_cin), .op_sub(l_sub),
      .out_valid(l_out_valid), .out_ready(l_out_ready),
      .sum(l_sum), .cout(l_cout), .ovf(l_ovf), .zero(l_zero)
    );

    initial begin
      logic [63:0] la, lb;
      int acc = 0, cycles = 0, t = 0;
      bit hold = 0;
      la = '0; lb = '0;
      repeat (3) @(posedge clk);
      #1 l_rst = 1'b0;
      while (acc < 10000 && cycles < 60000) begin
        if (!hold) begin
          la = pick(); lb = pick();
          l_a = la[LW-1:0]; l_b = lb[LW-1:0];
          l_cin = 1'($urandom_range(0, 1)); l_sub = 1'($urandom_range(0, 1));
          l_in_valid = ($urandom_range(0, 3) != 0);
        end
        l_out_ready = ($urandom_range(0, 3) != 0);
        @(negedge clk);
        if (l_in_valid && l_in_ready) begin
          lq.push_back(model(LW, la, lb, l_cin, l_sub));
          acc++;
          hold = 0;
        end else begin
          hold = l_in_valid;
        end
        @(posedge clk); #1;
        cycles++;
      end
      if (acc < 10000) begin
        checks++; errors++;
        $display("FAIL w%0d_stream_timeout: accepted %0d beats, required 10000", LW, acc);
      end
      l_in_valid  = 1'b0;
      l_out_ready = 1'b1;
      while (lq.size() != 0 && t < 500) begin
        @(negedge clk);
        t++;
      end
      if (lq.size() != 0) begin
        checks++; errors++;
        $display("FAIL w%0d_drain_timeout: %0d beats outstanding, required 0", LW, lq.size());
      end
      l_done = 1;
    end

    always @(negedge clk) begin
      exp_t e;
      if (!l_rst && l_out_valid && l_out_ready) begin
        if (lq.size() == 0) begin
          checks++; errors++;
          $display("FAIL w%0d_unexpected_beat: got sum 0x%0h, expected no output", LW, l_sum);
        end else begin
          e = lq.pop_front();
          check($sformatf("w%0d_sum", LW), 64'(l_sum), e.sum);
          check($sformatf("w%0d_cout", LW), l_cout, e.cout);
          check($sformatf("w%0d_ovf", LW), l_ovf, e.ovf);
          check($sformatf("w%0d_zero", LW), l_zero, e.zero);
        end
      end
    end
  end

  initial begin
    logic [63:0] ra, rb;
    int t;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_out_valid", out_valid, 1'b0);
    check("reset_sum", sum, '0);
    check("reset_flags", {cout, ovf, zero}, 3'b000);
    check("reset_in_ready", in_ready, 1'b1);
    @(posedge clk); #1;

    // Directed beats with spec-given results; each checks the exact latency.
    send_exp(16'h1234, 16'h4321, 1'b0, 1'b0, 1'b1, mk(64'h5555, 1'b0, 1'b0, 1'b0)); drain();
    send_exp(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b1, mk(64'h0000, 1'b1, 1'b0, 1'b1)); drain();
    send_exp(16'h0005, 16'h0007, 1'b1, 1'b1, 1'b1, mk(64'hFFFE, 1'b0, 1'b0, 1'b0)); drain();
    send_exp(16'h8000, 16'h0001, 1'b0, 1'b1, 1'b1, mk(64'h7FFF, 1'b1, 1'b1, 1'b0)); drain();
    send_exp(16'h7FFF, 16'h0000, 1'b1, 1'b0, 1'b1, mk(64'h8000, 1'b0, 1'b1, 1'b0)); drain();

    // Back-pressure: 10 back-to-back beats, out_ready low in stream cycles 8..12.
    fork
      begin
        for (int k = 0; k < 10; k++) begin
          ra = {$urandom, $urandom}; rb = {$urandom, $urandom};
          send(ra[W-1:0], rb[W-1:0], 1'b0, 1'b0, 1'b0);
        end
      end
      begin
        for (int k = 0; k < 30; k++) begin
          out_ready = !(k >= 8 && k <= 12);
          @(negedge clk);
          if (k >= 8 && k <= 12) check("bp_in_ready", in_ready, 1'b0);
          @(posedge clk); #1;
        end
      end
    join
    out_ready = 1'b1;
    drain();

    // Reset with three beats in flight: none may ever appear.
    for (int k = 0; k < 3; k++) begin
      ra = {$urandom, $urandom}; rb = {$urandom, $urandom};
      send(ra[W-1:0], rb[W-1:0], 1'b0, 1'b0, 1'b0);
    end
    rst = 1'b1;
    q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("midrst_out_valid", out_valid, 1'b0);
    check("midrst_sum", sum, '0);
    @(posedge clk); #1;
    repeat (12) @(posedge clk);
    #1;
    send(16'hA5A5, 16'h0F0F, 1'b1, 1'b0, 1'b1);
    drain();

    // Randomised 16-bit traffic with random downstream stalls.
    fork
      begin
        for (int k = 0; k < 10000; k++) begin
          if ($urandom_range(0, 3) == 0) begin
            @(posedge clk); #1;
          end
          ra = pick(); rb = pick();
          send(ra[W-1:0], rb[W-1:0], 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
        end
        rand16_done = 1;
      end
      begin
        while (!rand16_done) begin
          out_ready = ($urandom_range(0, 3) != 0);
          @(posedge clk); #1;
        end
      end
    join
    out_ready = 1'b1;
    drain();

    t = 0;
    while (!(g_lane[0].l_done && g_lane[1].l_done) && t < 80000) begin
      @(posedge clk);
      t++;
    end
    if (!(g_lane[0].l_done && g_lane[1].l_done)) begin
      checks++; errors++;
      $display("FAIL lanes_timeout: side lanes not finished after %0d cycles", t);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
